div_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU. Sits in EX, directly upstream of
//  the HI/LO register: produces remainder (HI) and quotient (LO) plus a one-cycle ready pulse

---
 rtl/div_unit_if.sv | 40 ++++
 rtl/div_unit.sv | 150 +++++++++++++++
 tb/tb_div_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
//------------------------------------------------------------------------------
// div_unit_if
//   Handshake and data bundle between the EX stage and the divider.
//   master: EX-stage side, issues requests and consumes results.
//   slave : divider side.
//   Signals:
//     start, signed_div, annul       request / control from EX
//     opdata1, opdata2 [WIDTH]       dividend (rs), divisor (rt)
//     result_hi, result_lo [WIDTH]   remainder, quotient
//     ready                          one-cycle HI/LO write enable
//     busy                           pipeline stall request
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic             annul;
  logic [WIDTH-1:0] opdata1;
  logic [WIDTH-1:0] opdata2;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             ready;
  logic             busy;

  modport master (
    output start, signed_div, annul, opdata1, opdata2,
    input  result_hi, result_lo, ready, busy
  );

  modport slave (
    input  start, signed_div, annul, opdata1, opdata2,
    output result_hi, result_lo, ready, busy
  );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
//------------------------------------------------------------------------------
// div_unit
//   Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU. One quotient bit
//   is produced per cycle on unsigned magnitudes; the sign fix-up is applied
//   when the result is committed to result_hi (remainder) / result_lo
//   (quotient) together with a one-cycle ready pulse.
//   Ports:
//     clk  in  clock, posedge
//     rst  in  asynchronous active-high reset
//     bus  div_unit_if.slave (start, signed_div, annul, opdata1, opdata2 in;
//          result_hi, result_lo, ready, busy out)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic  clk,
  input  wire logic  rst,
  div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] rem;        // partial remainder
  logic [WIDTH-1:0] quo;        // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] divisor;    // divisor magnitude
  logic [CNT_W-1:0] count;
  logic             neg_quo;
  logic             neg_rem;
  logic             div_zero;

  logic             load;
  logic             step;
  logic             commit;

  // Operand magnitudes. The most negative value wraps onto itself and is
  // then read as an unsigned magnitude, which is exactly 2^(WIDTH-1).
  logic [WIDTH-1:0] abs_a, abs_b;
  always_comb begin
    abs_a = bus.opdata1;
    abs_b = bus.opdata2;
    if (bus.signed_div && bus.opdata1[WIDTH-1]) abs_a = -bus.opdata1;
    if (bus.signed_div && bus.opdata2[WIDTH-1]) abs_b = -bus.opdata2;
  end

  // One restoring step. The shifted remainder is WIDTH+1 bits wide; when it
  // is >= divisor the difference is < divisor, so WIDTH bits hold it.
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] sub;
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    ge      = (shifted >= {1'b0, divisor});
    sub     = shifted[WIDTH-1:0] - divisor;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and control strobes
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.annul) begin
          load       = 1'b1;
          next_state = (bus.opdata2 == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (bus.annul) begin
          next_state = IDLE;
        end else begin
          step = 1'b1;
          if (count == LAST_ITER) next_state = DONE;
        end
      end
      DONE: begin
        // Annul is deliberately ignored here: the result is committed.
        commit     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem           <= '0;
      quo           <= '0;
      divisor       <= '0;
      count         <= '0;
      neg_quo       <= 1'b0;
      neg_rem       <= 1'b0;
      div_zero      <= 1'b0;
      bus.result_hi <= '0;
      bus.result_lo <= '0;
      bus.ready     <= 1'b0;
    end else begin
      bus.ready <= commit;
      if (load) begin
        rem      <= '0;
        divisor  <= abs_b;
        count    <= '0;
        div_zero <= (bus.opdata2 == '0);
        // Divide-by-zero reports the raw dividend, so keep it unmodified.
        quo      <= (bus.opdata2 == '0) ? bus.opdata1 : abs_a;
        neg_quo  <= bus.signed_div & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
        neg_rem  <= bus.signed_div & bus.opdata1[WIDTH-1];
      end
      if (step) begin
        rem   <= ge ? sub : shifted[WIDTH-1:0];
        quo   <= {quo[WIDTH-2:0], ge};
        count <= count + 1'b1;
      end
      if (commit) begin
        if (div_zero) begin
          bus.result_hi <= quo;
          bus.result_lo <= '1;
        end else begin
          bus.result_hi <= neg_rem ? -rem : rem;
          bus.result_lo <= neg_quo ? -quo : quo;
        end
      end
    end
  end

  assign bus.busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
//------------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit: directed corner cases, annul, async
//   reset, ignored start, back-to-back and randomized operations compared
//   against a plain-arithmetic reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {remainder, quotient} using 64-bit arithmetic so the
  // signed overflow case wraps naturally instead of trapping.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit s);
    bus.start      = 1'b1;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.signed_div = s;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.opdata1    = $urandom;
    bus.opdata2    = $urandom;
    bus.signed_div = 1'($urandom);
  endtask

  // Waits for ready; optionally pokes a junk start at cycle 'poke'.
  task automatic wait_result(input logic [31:0] a, input logic [31:0] b, input bit s, input int poke);
    logic [63:0] exp;
    int cyc, busy_n, lat;
    exp    = model(a, b, s);
    lat    = (b == 32'd0) ? 1 : 33;
    cyc    = 0;
    busy_n = 0;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    if (bus.busy) busy_n++;
    while (!bus.ready && cyc < 100) begin
      if (poke != 0 && cyc == poke) begin
        bus.start   = 1'b1;
        bus.opdata1 = 32'd9;
        bus.opdata2 = 32'd3;
      end
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
      if (bus.busy) busy_n++;
    end
    check("latency", 32'(cyc), 32'(lat));
    check("busy_cycles", 32'(busy_n), 32'(lat));
    check("result_hi", bus.result_hi, exp[63:32]);
    check("result_lo", bus.result_lo, exp[31:0]);
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit s, input int poke);
    logic [63:0] exp;
    exp = model(a, b, s);
    start_op(a, b, s);
    wait_result(a, b, s, poke);
    @(negedge clk);
    check("ready_one_cycle", {31'd0, bus.ready}, 32'd0);
    check("hi_hold", bus.result_hi, exp[63:32]);
    check("lo_hold", bus.result_lo, exp[31:0]);
  endtask

  // Runs n cycles and checks ready never rises and results hold.
  task automatic quiet(input int n, input logic [31:0] hi, input logic [31:0] lo);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.ready) seen++;
    end
    check("no_ready", 32'(seen), 32'd0);
    check("quiet_hi", bus.result_hi, hi);
    check("quiet_lo", bus.result_lo, lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bit s;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.annul      = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", bus.result_hi, 32'd0);
    check("rst_lo", bus.result_lo, 32'd0);
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_div(32'd100, 32'd7, 1'b0, 0);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    do_div(32'h0000_1234, 32'd0, 1'b0, 0);
    do_div(32'hFFFF_FF00, 32'd0, 1'b1, 0);
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    do_div(32'd5, 32'd9, 1'b0, 0);

    // Start while busy is ignored
    do_div(32'd1000, 32'd13, 1'b0, 5);

    // Start with annul in IDLE does nothing
    bus.start = 1'b1; bus.annul = 1'b1; bus.opdata1 = 32'd77; bus.opdata2 = 32'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.annul = 1'b0;
    check("annul_idle_busy", {31'd0, bus.busy}, 32'd0);
    quiet(3, 32'd12, 32'd76);

    // Annul mid-BUSY
    start_op(32'd50000, 32'd123, 1'b0);
    repeat (10) @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    check("annul_busy", {31'd0, bus.busy}, 32'd0);
    quiet(40, 32'd12, 32'd76);
    do_div(32'd50000, 32'd123, 1'b0, 0);

    // Async reset mid-BUSY
    start_op(32'd1000, 32'd3, 1'b1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_hi", bus.result_hi, 32'd0);
    check("arst_lo", bus.result_lo, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_ready", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet(40, 32'd0, 32'd0);

    // Back-to-back: second start in the ready cycle
    start_op(32'd12345, 32'd10, 1'b0);
    wait_result(32'd12345, 32'd10, 1'b0, 0);
    start_op(32'hFFFF_0000, 32'd0, 1'b1);
    wait_result(32'hFFFF_0000, 32'd0, 1'b1, 0);
    start_op(32'hF000_0001, 32'd3, 1'b1);
    wait_result(32'hF000_0001, 32'd3, 1'b1, 0);
    @(negedge clk);
    check("b2b_ready_drop", {31'd0, bus.ready}, 32'd0);

    // Randomized
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      s = 1'($urandom);
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'd0;
        3: b = -32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      do_div(a, b, s, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
